pipeline_flush_ctrl: RTL and testbench
======================================

# pipeline_flush_ctrl

Central stall/flush sequencer for the front of the core pipeline. It collects stall sources (data-cache miss, mul/div busy, CSR serialisation, load-use hazard, I-cache miss) and redirect events (exception, ERET, FENCE.I, branch mispredict). From these it drives `lock_PIPELINE`, `lock_FETCH`, `FLUSH_P1` and `FLUSH_P2` to the fetch/decode pipeline latch, and the redirect select to the PC generator. A small FSM sequences multi-cycle events: the FENCE.I drain/invalidate and the post-flush fetch hold.

## Interface
Parameters:
- `HOLD_CYCLES`, default 2: cycles `lock_FETCH` stays high after any flush/redirect. Legal range ≥1.
- `CNT_W`, default 32: width of the flush performance counter.

Ports:
- `CLK` in 1: clock, rising edge.
- `RST` in 1: asynchronous active-low reset.
- `MEM_STALL` in 1: data cache not ready.
- `MULDIV_BUSY` in 1: multi-cycle unit busy.
- `CSR_STALL` in 1: CSR serialisation.
- `LOAD_USE` in 1: decode load-use hazard.
- `ICACHE_MISS` in 1: fetch miss.
- `XCPT_TAKEN` in 1: commit takes exception/interrupt.
- `ERET` in 1: commit executes xRET.
- `FENCE_I` in 1: commit executes FENCE.I.
- `BRANCH_MISS` in 1: execute resolves a mispredict.
- `STORE_BUF_EMPTY` in 1: store buffer drained.
- `ICACHE_INVAL_DONE` in 1: I-cache invalidate complete.
- `lock_PIPELINE` out 1: freeze all pipeline latches.
- `lock_FETCH` out 1: freeze PC/fetch.
- `FLUSH_P1` out 1: kill, overrides lock.
- `FLUSH_P2` out 1: kill, yields to lock.
- `ICACHE_INVAL` out 1: one-cycle invalidate request.
- `REDIRECT_VALID` out 1: PC generator loads the selected target.
- `REDIRECT_SEL` out 2: 0 = branch target, 1 = trap vector, 2 = EPC, 3 = FENCE.I PC+4.
- `PERF_FLUSH_CNT` out `CNT_W`: saturating count of flush cycles.

## Operation
- States: RUN, HOLD, DRAIN, INV. Reset: RUN, hold counter 0, `PERF_FLUSH_CNT` 0.
- While `RST`=0, all outputs are 0.
- `lock_PIPELINE` = `MEM_STALL | MULDIV_BUSY | CSR_STALL` in every state.
- `lock_FETCH` = `lock_PIPELINE | LOAD_USE | ICACHE_MISS | (state != RUN)`.
- Event priority within a cycle: `XCPT_TAKEN` > `ERET` > `FENCE_I` > `BRANCH_MISS`. Only the winner acts.

RUN:
- `XCPT_TAKEN`: `FLUSH_P1`=1, `REDIRECT_VALID`=1, `REDIRECT_SEL`=1 → HOLD.
- `ERET`: as above with `REDIRECT_SEL`=2 → HOLD.
- `FENCE_I`: `FLUSH_P1`=1, no redirect → DRAIN.
- `BRANCH_MISS` with `lock_PIPELINE`=0: `FLUSH_P2`=1, `REDIRECT_VALID`=1, `REDIRECT_SEL`=0 → HOLD.
- `BRANCH_MISS` with `lock_PIPELINE`=1: ignored. Execute re-presents the branch.

HOLD:
- On entry, the counter loads `HOLD_CYCLES`. It decrements each cycle and the FSM returns to RUN in the cycle after the counter reaches 1.
- `XCPT_TAKEN`/`ERET` in HOLD re-flush and redirect as in RUN, and reload the counter.
- `BRANCH_MISS` and `FENCE_I` in HOLD are ignored (wrong path).

DRAIN:
- Wait for `STORE_BUF_EMPTY`=1. Then pulse `ICACHE_INVAL` for one cycle → INV.
- `XCPT_TAKEN` in DRAIN aborts the fence: `FLUSH_P1`, redirect `SEL`=1 → HOLD.

INV:
- Wait for `ICACHE_INVAL_DONE`. Then `REDIRECT_VALID`=1, `SEL`=3 → HOLD.
- `XCPT_TAKEN` in INV is deferred until the transition to HOLD.
- Invalidation is never aborted.

Counter and redirect rules:
- `PERF_FLUSH_CNT` increments by 1 in any cycle with `FLUSH_P1|FLUSH_P2`. It holds at all-ones.
- `REDIRECT_SEL` is 0 whenever `REDIRECT_VALID`=0.

## Timing
- `lock_*`, `FLUSH_*`, `REDIRECT_*` and `ICACHE_INVAL` are combinational from current state plus inputs (same-cycle response).
- State, hold counter and perf counter are registered.
- Flush-to-fetch-resume latency: `HOLD_CYCLES`+1 cycles (event cycle plus HOLD).
- FENCE.I minimum latency: event, ≥1 DRAIN, ≥1 INV, then HOLD.
- Asynchronous reset mid-sequence returns to RUN immediately.
- No pending event survives reset.

## Structure
- Shared package entries: state enum (RUN/HOLD/DRAIN/INV) and `REDIRECT_SEL` encodings. The PC generator decodes the same constants.
- One natural sub-module: `sat_counter` (parameterised width, increment, saturate), used for `PERF_FLUSH_CNT`.
- Hold counter and FSM stay inline.

## Test plan
- Reset, then `MEM_STALL`=1 → `lock_PIPELINE`=1, `lock_FETCH`=1, no flush.
- `BRANCH_MISS` in RUN with `HOLD_CYCLES`=2 → `FLUSH_P2`=1, `SEL`=0 at cycle 0; `lock_FETCH`=1 in cycles 1–2; RUN at cycle 3; `PERF_FLUSH_CNT`=1.
- `BRANCH_MISS`+`MULDIV_BUSY` together → no flush, no redirect. Release the stall with `BRANCH_MISS` still high → `FLUSH_P2` in that cycle.
- `XCPT_TAKEN`+`ERET`+`BRANCH_MISS` in the same cycle → only `FLUSH_P1`, `SEL`=1.
- `FENCE_I`, `STORE_BUF_EMPTY` held 0 for 3 cycles then 1 → one-cycle `ICACHE_INVAL`. Then `ICACHE_INVAL_DONE` after 4 cycles → `REDIRECT_VALID`, `SEL`=3.
- Perf counter preloaded to all-ones, then a flush → stays all-ones. Deassert `RST` mid-DRAIN → outputs 0, state RUN.

Source files
------------

// File: rtl/pipeline_flush_ctrl_pkg.sv
// Shared encodings for the front-end stall/flush sequencer and the PC generator
// that decodes its redirect select.
package pipeline_flush_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_HOLD  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_INV   = 2'd3
  } state_e;

  localparam logic [1:0] SEL_BRANCH = 2'd0;
  localparam logic [1:0] SEL_TRAP   = 2'd1;
  localparam logic [1:0] SEL_EPC    = 2'd2;
  localparam logic [1:0] SEL_FENCE  = 2'd3;

endpackage

// File: rtl/pipeline_flush_ctrl_sat_counter.sv
// Saturating up-counter: increments on inc_i and sticks at all-ones.
module pipeline_flush_ctrl_sat_counter #(
  parameter int unsigned W = 32
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc_i && (cnt_q != '1)) cnt_d = cnt_q + W'(1);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/pipeline_flush_ctrl.sv
// Central stall/flush sequencer: combines stall sources and redirect events into
// pipeline lock/flush controls, sequencing FENCE.I drain/invalidate and fetch hold.
module pipeline_flush_ctrl
  import pipeline_flush_ctrl_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES = 2,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             MEM_STALL,
  input  logic             MULDIV_BUSY,
  input  logic             CSR_STALL,
  input  logic             LOAD_USE,
  input  logic             ICACHE_MISS,
  input  logic             XCPT_TAKEN,
  input  logic             ERET,
  input  logic             FENCE_I,
  input  logic             BRANCH_MISS,
  input  logic             STORE_BUF_EMPTY,
  input  logic             ICACHE_INVAL_DONE,
  output logic             lock_PIPELINE,
  output logic             lock_FETCH,
  output logic             FLUSH_P1,
  output logic             FLUSH_P2,
  output logic             ICACHE_INVAL,
  output logic             REDIRECT_VALID,
  output logic [1:0]       REDIRECT_SEL,
  output logic [CNT_W-1:0] PERF_FLUSH_CNT
);

  localparam int unsigned       HCNT_W    = $clog2(HOLD_CYCLES + 1);
  localparam logic [HCNT_W-1:0] HOLD_INIT = HCNT_W'(HOLD_CYCLES);
  localparam logic [HCNT_W-1:0] HOLD_LAST = HCNT_W'(1);

  state_e            state_q, state_d;
  logic [HCNT_W-1:0] hold_q, hold_d;
  logic              xcpt_pend_q, xcpt_pend_d;

  logic       lock_pipe, flush_p1, flush_p2, inval, redir_vld;
  logic [1:0] redir_sel;

  assign lock_pipe = MEM_STALL | MULDIV_BUSY | CSR_STALL;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q     <= ST_RUN;
      hold_q      <= '0;
      xcpt_pend_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      xcpt_pend_q <= xcpt_pend_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    hold_d      = hold_q;
    xcpt_pend_d = xcpt_pend_q;
    flush_p1    = 1'b0;
    flush_p2    = 1'b0;
    inval       = 1'b0;
    redir_vld   = 1'b0;
    redir_sel   = SEL_BRANCH;

    unique case (state_q)
      ST_RUN, ST_HOLD: begin
        if (XCPT_TAKEN || ERET) begin
          flush_p1  = 1'b1;
          redir_vld = 1'b1;
          redir_sel = XCPT_TAKEN ? SEL_TRAP : SEL_EPC;
          state_d   = ST_HOLD;
          hold_d    = HOLD_INIT;
        end else if (state_q == ST_RUN) begin
          if (FENCE_I) begin
            flush_p1 = 1'b1;
            state_d  = ST_DRAIN;
          end else if (BRANCH_MISS && !lock_pipe) begin
            // A stalled mispredict is dropped; execute presents it again later.
            flush_p2  = 1'b1;
            redir_vld = 1'b1;
            redir_sel = SEL_BRANCH;
            state_d   = ST_HOLD;
            hold_d    = HOLD_INIT;
          end
        end else begin
          hold_d = hold_q - HOLD_LAST;
          if (hold_q <= HOLD_LAST) state_d = ST_RUN;
        end
      end
      ST_DRAIN: begin
        if (XCPT_TAKEN) begin
          flush_p1  = 1'b1;
          redir_vld = 1'b1;
          redir_sel = SEL_TRAP;
          state_d   = ST_HOLD;
          hold_d    = HOLD_INIT;
        end else if (STORE_BUF_EMPTY) begin
          inval   = 1'b1;
          state_d = ST_INV;
        end
      end
      ST_INV: begin
        // Invalidation always completes; an exception seen meanwhile wins the redirect.
        if (ICACHE_INVAL_DONE) begin
          redir_vld   = 1'b1;
          state_d     = ST_HOLD;
          hold_d      = HOLD_INIT;
          xcpt_pend_d = 1'b0;
          if (XCPT_TAKEN || xcpt_pend_q) begin
            flush_p1  = 1'b1;
            redir_sel = SEL_TRAP;
          end else begin
            redir_sel = SEL_FENCE;
          end
        end else if (XCPT_TAKEN) begin
          xcpt_pend_d = 1'b1;
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  assign lock_PIPELINE  = RST & lock_pipe;
  assign lock_FETCH     = RST & (lock_pipe | LOAD_USE | ICACHE_MISS | (state_q != ST_RUN));
  assign FLUSH_P1       = RST & flush_p1;
  assign FLUSH_P2       = RST & flush_p2;
  assign ICACHE_INVAL   = RST & inval;
  assign REDIRECT_VALID = RST & redir_vld;
  assign REDIRECT_SEL   = (RST && redir_vld) ? redir_sel : SEL_BRANCH;

  pipeline_flush_ctrl_sat_counter #(
    .W (CNT_W)
  ) u_perf_cnt (
    .clk_i  (CLK),
    .rst_ni (RST),
    .inc_i  (FLUSH_P1 | FLUSH_P2),
    .cnt_o  (PERF_FLUSH_CNT)
  );

endmodule

// File: tb/tb_pipeline_flush_ctrl.sv
// Table-driven bench for pipeline_flush_ctrl with a queue scoreboard and
// hand-written reset sequences.
module tb_pipeline_flush_ctrl;

  localparam int unsigned CNT_W = 4;

  // Input bit masks {MEM,MD,CSR,LU,IM,XC,ER,FI,BM,SBE,IDN}
  localparam logic [10:0] NONE = 11'd0;
  localparam logic [10:0] MEM  = 11'b100_0000_0000;
  localparam logic [10:0] MD   = 11'b010_0000_0000;
  localparam logic [10:0] LU   = 11'b000_1000_0000;
  localparam logic [10:0] IM   = 11'b000_0100_0000;
  localparam logic [10:0] XC   = 11'b000_0010_0000;
  localparam logic [10:0] ER   = 11'b000_0001_0000;
  localparam logic [10:0] FI   = 11'b000_0000_1000;
  localparam logic [10:0] BM   = 11'b000_0000_0100;
  localparam logic [10:0] SBE  = 11'b000_0000_0010;
  localparam logic [10:0] IDN  = 11'b000_0000_0001;

  // Output masks {lockP,lockF,P1,P2,INV,RV,SEL[1:0]}
  localparam logic [7:0] Z  = 8'h00;
  localparam logic [7:0] LP = 8'h80;
  localparam logic [7:0] LF = 8'h40;
  localparam logic [7:0] P1 = 8'h20;
  localparam logic [7:0] P2 = 8'h10;
  localparam logic [7:0] IV = 8'h08;
  localparam logic [7:0] RV = 8'h04;
  localparam logic [7:0] S1 = 8'h01;
  localparam logic [7:0] S2 = 8'h02;
  localparam logic [7:0] S3 = 8'h03;

  typedef struct {
    string       name;
    logic [10:0] in;
    logic [7:0]  exp;
  } vec_t;

  typedef struct {
    string            name;
    logic [7:0]       exp;
    logic [CNT_W-1:0] cnt;
  } sb_t;

  logic CLK = 1'b0;
  logic RST = 1'b0;
  logic MEM_STALL, MULDIV_BUSY, CSR_STALL, LOAD_USE, ICACHE_MISS;
  logic XCPT_TAKEN, ERET, FENCE_I, BRANCH_MISS, STORE_BUF_EMPTY, ICACHE_INVAL_DONE;
  logic lock_PIPELINE, lock_FETCH, FLUSH_P1, FLUSH_P2, ICACHE_INVAL, REDIRECT_VALID;
  logic [1:0]       REDIRECT_SEL;
  logic [CNT_W-1:0] PERF_FLUSH_CNT;
  logic [7:0]       out_v;

  int errors = 0;
  int checks = 0;
  vec_t vecs[$];
  sb_t  sb[$];
  sb_t  cur;
  logic [CNT_W-1:0] exp_cnt = '0;

  always #5 CLK = ~CLK;

  pipeline_flush_ctrl #(
    .HOLD_CYCLES (2),
    .CNT_W       (CNT_W)
  ) dut (
    .CLK               (CLK),
    .RST               (RST),
    .MEM_STALL         (MEM_STALL),
    .MULDIV_BUSY       (MULDIV_BUSY),
    .CSR_STALL         (CSR_STALL),
    .LOAD_USE          (LOAD_USE),
    .ICACHE_MISS       (ICACHE_MISS),
    .XCPT_TAKEN        (XCPT_TAKEN),
    .ERET              (ERET),
    .FENCE_I           (FENCE_I),
    .BRANCH_MISS       (BRANCH_MISS),
    .STORE_BUF_EMPTY   (STORE_BUF_EMPTY),
    .ICACHE_INVAL_DONE (ICACHE_INVAL_DONE),
    .lock_PIPELINE     (lock_PIPELINE),
    .lock_FETCH        (lock_FETCH),
    .FLUSH_P1          (FLUSH_P1),
    .FLUSH_P2          (FLUSH_P2),
    .ICACHE_INVAL      (ICACHE_INVAL),
    .REDIRECT_VALID    (REDIRECT_VALID),
    .REDIRECT_SEL      (REDIRECT_SEL),
    .PERF_FLUSH_CNT    (PERF_FLUSH_CNT)
  );

  assign out_v = {lock_PIPELINE, lock_FETCH, FLUSH_P1, FLUSH_P2,
                  ICACHE_INVAL, REDIRECT_VALID, REDIRECT_SEL};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [10:0] in);
    {MEM_STALL, MULDIV_BUSY, CSR_STALL, LOAD_USE, ICACHE_MISS, XCPT_TAKEN,
     ERET, FENCE_I, BRANCH_MISS, STORE_BUF_EMPTY, ICACHE_INVAL_DONE} = in;
  endtask

  function automatic void add(input string name, input logic [10:0] in, input logic [7:0] exp);
    vec_t v;
    v.name = name;
    v.in   = in;
    v.exp  = exp;
    vecs.push_back(v);
  endfunction

  task automatic apply(input vec_t v);
    sb_t e;
    @(posedge CLK);
    #1;
    drive(v.in);
    e.name = v.name;
    e.exp  = v.exp;
    e.cnt  = exp_cnt;
    sb.push_back(e);
    if ((v.exp & (P1 | P2)) != Z && exp_cnt != '1) exp_cnt = exp_cnt + 1'b1;
  endtask

  always @(negedge CLK) begin
    if (sb.size() != 0) begin
      cur = sb.pop_front();
      chk({cur.name, "/out"}, 32'(out_v), 32'(cur.exp));
      chk({cur.name, "/cnt"}, 32'(PERF_FLUSH_CNT), 32'(cur.cnt));
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    drive(NONE);
    // Reset-time behaviour and HOLD_CYCLES=2 timings are hand-derived below.
    add("idle",          NONE,          Z);
    add("mem_stall",     MEM,           LP | LF);
    add("load_use",      LU,            LF);
    add("icache_miss",   IM,            LF);
    add("bm_run",        BM,            P2 | RV);
    add("bm_hold1",      NONE,          LF);
    add("bm_hold2",      NONE,          LF);
    add("bm_resume",     NONE,          Z);
    add("bm_stalled",    BM | MD,       LP | LF);
    add("bm_released",   BM,            P2 | RV);
    add("hold_ignore",   BM | FI,       LF);
    add("hold_last",     NONE,          LF);
    add("prio_xcpt",     XC | ER | BM,  P1 | RV | S1);
    add("eret_in_hold",  ER,            LF | P1 | RV | S2);
    add("reload1",       NONE,          LF);
    add("reload2",       NONE,          LF);
    add("reload_done",   NONE,          Z);
    add("fence",         FI,            P1);
    for (int i = 0; i < 3; i++) add("drain_wait", NONE, LF);
    add("drain_done",    SBE,           LF | IV);
    for (int i = 0; i < 4; i++) add("inv_wait", NONE, LF);
    add("inv_done",      IDN,           LF | RV | S3);
    add("fence_hold1",   NONE,          LF);
    add("fence_hold2",   NONE,          LF);
    add("fence_resume",  NONE,          Z);
    add("fence2",        FI,            P1);
    add("drain_abort",   XC,            LF | P1 | RV | S1);
    add("abort_hold1",   NONE,          LF);
    add("abort_hold2",   NONE,          LF);
    add("abort_resume",  NONE,          Z);
    add("fence3",        FI,            P1);
    add("drain_done3",   SBE,           LF | IV);
    add("inv_xcpt_defer", XC,           LF);
    add("inv_done_xcpt", IDN,           LF | P1 | RV | S1);
    add("defer_hold1",   NONE,          LF);
    add("defer_hold2",   NONE,          LF);
    add("defer_resume",  NONE,          Z);
    add("xcpt_locked",   XC | MEM,      LP | LF | P1 | RV | S1);
    add("xl_hold1",      NONE,          LF);
    add("xl_hold2",      NONE,          LF);
    add("xl_resume",     NONE,          Z);
    for (int i = 0; i < 8; i++) begin
      add("sat_bm",    BM,   P2 | RV);
      add("sat_hold1", NONE, LF);
      add("sat_hold2", NONE, LF);
    end
    add("sat_final",     NONE,          Z);

    // Reset with events asserted: everything must read zero.
    drive(MEM | XC | FI | SBE);
    #12;
    chk("reset/out", 32'(out_v), 32'(Z));
    chk("reset/cnt", 32'(PERF_FLUSH_CNT), 32'(0));
    @(posedge CLK);
    #1;
    drive(NONE);
    RST = 1'b1;

    foreach (vecs[i]) apply(vecs[i]);
    @(posedge CLK);
    #1;
    drive(NONE);
    for (int i = 0; i < 10 && sb.size() != 0; i++) @(posedge CLK);
    if (sb.size() != 0) chk("sb_drain", 32'(sb.size()), 32'(0));

    // Asynchronous reset in the middle of a FENCE.I drain.
    @(posedge CLK);
    #1;
    drive(FI);
    @(negedge CLK);
    chk("mid/fence", 32'(out_v), 32'(P1));
    @(posedge CLK);
    #1;
    drive(SBE | MEM);
    #1;
    chk("mid/drain", 32'(out_v), 32'(LP | LF | IV));
    RST = 1'b0;
    #1;
    chk("mid/rst_out", 32'(out_v), 32'(Z));
    chk("mid/rst_cnt", 32'(PERF_FLUSH_CNT), 32'(0));
    @(posedge CLK);
    #1;
    RST = 1'b1;
    drive(SBE);
    @(negedge CLK);
    chk("post_rst/run", 32'(out_v), 32'(Z));
    chk("post_rst/cnt", 32'(PERF_FLUSH_CNT), 32'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
